// File: rtl/baud_rate_generator_prog.sv
`default_nettype none
// ============================================================================
//  Module      : baud_rate_generator_prog
//  Description : Programmable baud-rate generator. A divisor counter produces
//                an oversample strobe (tick) every div_active+1 enabled
//                clocks; an oversample counter divides tick by OVERSAMPLE to
//                produce bit_tick. A new divisor is staged in a pending
//                register and takes effect at the next counter wrap or on a
//                restart, so a period in flight is never truncated.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock       in   system clock, rising edge active
//    reset_n     in   asynchronous reset, active low
//    enable      in   1 = counters advance; 0 = hold, strobes forced low
//    restart     in   single-cycle pulse, realigns phase to zero
//    div_load    in   single-cycle strobe, captures div_value
//    div_value   in   requested divisor (CNT_WIDTH bits)
//    tick        out  registered oversample strobe
//    bit_tick    out  registered strobe, once per OVERSAMPLE ticks
//    div_pending out  1 while a loaded divisor awaits application
//    div_active  out  divisor currently in use (CNT_WIDTH bits)
// ============================================================================
module baud_rate_generator_prog #(
   parameter int CNT_WIDTH   = 16,
   parameter int DEFAULT_DIV = 163,
   parameter int OVERSAMPLE  = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 restart,
   input  logic                 div_load,
   input  logic [CNT_WIDTH-1:0] div_value,
   output logic                 tick,
   output logic                 bit_tick,
   output logic                 div_pending,
   output logic [CNT_WIDTH-1:0] div_active
);

   // Oversample counter needs at least one bit even when OVERSAMPLE is 1.
   localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

   localparam logic [CNT_WIDTH-1:0] c_default_div = CNT_WIDTH'(DEFAULT_DIV);
   localparam logic [OS_W-1:0]      c_os_last     = OS_W'(OVERSAMPLE - 1);

   generate
      if ((OVERSAMPLE < 1) ||
          ((CNT_WIDTH < 32) && (DEFAULT_DIV >= (1 << CNT_WIDTH)))) begin : g_bad_params
         $fatal(1, "baud_rate_generator_prog: DEFAULT_DIV out of range or OVERSAMPLE < 1");
      end
   endgenerate

   logic [CNT_WIDTH-1:0] r_div_cnt;
   logic [OS_W-1:0]      r_os_cnt;
   logic                 r_tick;
   logic                 r_bit_tick;
   logic [CNT_WIDTH-1:0] r_div_active;
   logic [CNT_WIDTH-1:0] r_pend_val;
   logic                 r_pending;

   logic                 w_wrap;
   logic                 w_os_wrap;
   logic [CNT_WIDTH-1:0] w_next_div;

   // Equality compare is sufficient: div_active only changes at a wrap or a
   // restart, both of which zero the counter, so it can never overshoot.
   assign w_wrap    = (r_div_cnt == r_div_active);
   assign w_os_wrap = (r_os_cnt == c_os_last);

   // Divisor to use for the next period when a wrap or restart happens now.
   // A same-edge load bypasses the pending register entirely.
   assign w_next_div = div_load  ? div_value  :
                       r_pending ? r_pend_val : r_div_active;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_div_cnt    <= '0;
         r_os_cnt     <= '0;
         r_tick       <= 1'b0;
         r_bit_tick   <= 1'b0;
         r_div_active <= c_default_div;
         r_pend_val   <= c_default_div;
         r_pending    <= 1'b0;
      end else if (restart) begin
         // Restart dominates both enable and a coincident wrap.
         r_div_cnt    <= '0;
         r_os_cnt     <= '0;
         r_tick       <= 1'b0;
         r_bit_tick   <= 1'b0;
         r_div_active <= w_next_div;
         r_pending    <= 1'b0;
         if (div_load) begin
            r_pend_val <= div_value;
         end
      end else begin
         r_tick     <= 1'b0;
         r_bit_tick <= 1'b0;
         if (div_load) begin
            r_pend_val <= div_value;
         end
         if (enable && w_wrap) begin
            r_div_cnt    <= '0;
            r_tick       <= 1'b1;
            r_bit_tick   <= w_os_wrap;
            r_os_cnt     <= w_os_wrap ? '0 : (r_os_cnt + OS_W'(1));
            r_div_active <= w_next_div;
            r_pending    <= 1'b0;
         end else begin
            if (enable) begin
               r_div_cnt <= r_div_cnt + CNT_WIDTH'(1);
            end
            if (div_load) begin
               r_pending <= 1'b1;
            end
         end
      end
   end

   assign tick        = r_tick;
   assign bit_tick    = r_bit_tick;
   assign div_pending = r_pending;
   assign div_active  = r_div_active;

endmodule
`default_nettype wire

// File: tb/tb_baud_rate_generator_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_baud_rate_generator_prog
//  Description : Self-checking bench for baud_rate_generator_prog. A
//                countdown reference model (edges remaining until the next
//                tick, ticks remaining until the next bit_tick) is compared
//                against the DUT after every clock edge, and directed
//                scenarios check absolute tick edge numbers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_baud_rate_generator_prog;

   localparam int CW  = 16;
   localparam int DEF = 163;
   localparam int OS  = 16;

   logic          clock;
   logic          reset_n;
   logic          enable;
   logic          restart;
   logic          div_load;
   logic [CW-1:0] div_value;
   logic          tick;
   logic          bit_tick;
   logic          div_pending;
   logic [CW-1:0] div_active;

   baud_rate_generator_prog #(
      .CNT_WIDTH   (CW),
      .DEFAULT_DIV (DEF),
      .OVERSAMPLE  (OS)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .restart     (restart),
      .div_load    (div_load),
      .div_value   (div_value),
      .tick        (tick),
      .bit_tick    (bit_tick),
      .div_pending (div_pending),
      .div_active  (div_active)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int total = 0;
   int bad   = 0;
   int edge_no;
   int tick_edges[$];
   int bit_edges[$];

   // Reference model state
   int m_rem;      // enabled edges left until the next tick
   int m_os_left;  // ticks left until the next bit_tick
   int m_act;
   int m_pval;
   bit m_pend;
   bit m_tick;
   bit m_bit;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int idx);
      return (q.size() > idx) ? q[idx] : -1;
   endfunction

   task automatic model_reset();
      m_rem     = DEF + 1;
      m_os_left = OS;
      m_act     = DEF;
      m_pval    = DEF;
      m_pend    = 1'b0;
      m_tick    = 1'b0;
      m_bit     = 1'b0;
   endtask

   task automatic model_edge();
      int nd;
      nd = div_load ? int'(div_value) : (m_pend ? m_pval : m_act);
      m_tick = 1'b0;
      m_bit  = 1'b0;
      if (restart) begin
         m_act     = nd;
         m_pend    = 1'b0;
         m_rem     = nd + 1;
         m_os_left = OS;
      end else if (enable && m_rem == 1) begin
         m_tick    = 1'b1;
         m_os_left = m_os_left - 1;
         if (m_os_left == 0) begin
            m_bit     = 1'b1;
            m_os_left = OS;
         end
         m_act  = nd;
         m_pend = 1'b0;
         m_rem  = nd + 1;
      end else begin
         if (enable) m_rem = m_rem - 1;
         if (div_load) begin
            m_pval = int'(div_value);
            m_pend = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      edge_no++;
      model_edge();
      #1;
      chk("tick", tick, m_tick);
      chk("bit_tick", bit_tick, m_bit);
      chk("div_pending", div_pending, m_pend);
      chk("div_active", div_active, m_act);
      if (tick)     tick_edges.push_back(edge_no);
      if (bit_tick) bit_edges.push_back(edge_no);
   endtask

   task automatic run_to(input int n);
      while (edge_no < n) step();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_tick", tick, 0);
      chk("rst_bit_tick", bit_tick, 0);
      chk("rst_pending", div_pending, 0);
      chk("rst_active", div_active, DEF);
      #2 reset_n = 1'b1;
      model_reset();
      edge_no = 0;
      tick_edges.delete();
      bit_edges.delete();
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b0;
      restart   = 1'b0;
      div_load  = 1'b0;
      div_value = '0;
      repeat (2) @(posedge clock);
      #1;
      do_reset();
      enable = 1'b1;

      // Mid-period load of 9 at edge 50
      run_to(49);
      div_load = 1'b1; div_value = 16'd9;
      step();
      div_load = 1'b0;
      run_to(163);
      chk("load9_pending", div_pending, 1);
      step();
      chk("load9_active", div_active, 9);
      chk("load9_pend_clr", div_pending, 0);
      run_to(190);
      chk("load9_t0", qget(tick_edges, 0), 164);
      chk("load9_t1", qget(tick_edges, 1), 174);
      chk("load9_t2", qget(tick_edges, 2), 184);

      // Load of 3 on the wrap edge 164
      do_reset();
      run_to(163);
      div_load = 1'b1; div_value = 16'd3;
      step();
      div_load = 1'b0;
      chk("wrapload_pending", div_pending, 0);
      chk("wrapload_active", div_active, 3);
      run_to(170);
      chk("wrapload_t0", qget(tick_edges, 0), 164);
      chk("wrapload_t1", qget(tick_edges, 1), 168);

      // Pause 20 cycles at counter value 100
      do_reset();
      run_to(100);
      enable = 1'b0;
      repeat (20) step();
      enable = 1'b1;
      run_to(200);
      chk("pause_t0", qget(tick_edges, 0), 184);

      // Restart at counter value 80 with load of 4
      do_reset();
      run_to(80);
      restart = 1'b1; div_load = 1'b1; div_value = 16'd4;
      step();
      restart = 1'b0; div_load = 1'b0;
      chk("restart_tick", tick, 0);
      chk("restart_active", div_active, 4);
      run_to(180);
      chk("restart_t0", qget(tick_edges, 0), 86);
      chk("restart_t1", qget(tick_edges, 1), 91);
      chk("restart_b0", qget(bit_edges, 0), 81 + 16 * 5);

      // Async reset while a divisor is pending
      do_reset();
      run_to(30);
      div_load = 1'b1; div_value = 16'd9;
      step();
      div_load = 1'b0;
      chk("pend_before_rst", div_pending, 1);
      do_reset();
      run_to(170);
      chk("rstpend_t0", qget(tick_edges, 0), 164);

      // Default schedule, long run
      do_reset();
      run_to(2630);
      chk("def_t0", qget(tick_edges, 0), 164);
      chk("def_t1", qget(tick_edges, 1), 328);
      chk("def_t2", qget(tick_edges, 2), 492);
      chk("def_b0", qget(bit_edges, 0), 2624);
      chk("def_nticks", tick_edges.size(), 16);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         enable    = ($urandom_range(0, 9) != 0);
         restart   = ($urandom_range(0, 199) == 0);
         div_load  = ($urandom_range(0, 29) == 0);
         div_value = CW'($urandom_range(0, 6));
         step();
      end
      restart  = 1'b0;
      div_load = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/baud_rate_generator_prog.md
BAUD_RATE_GENERATOR_PROG -- requirements
Module: baud_rate_generator_prog

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter CNT_WIDTH SHALL default to 16 and set the divisor counter width in bits.
REQ-003 Parameter DEFAULT_DIV SHALL default to 163 and set the divisor active out of reset.
REQ-004 Parameter OVERSAMPLE SHALL default to 16 and set the number of ticks per bit_tick.
REQ-005 Port clock SHALL be an input, 1 bit wide: the system clock, rising-edge active.
REQ-006 Port reset_n SHALL be an input, 1 bit wide: asynchronous reset, active low.
REQ-007 Port enable SHALL be an input, 1 bit wide: when 1, the counters advance.
REQ-008 Port restart SHALL be an input, 1 bit wide: a single-cycle pulse that realigns the phase.
REQ-009 Port div_load SHALL be an input, 1 bit wide: a single-cycle strobe that captures div_value.
REQ-010 Port div_value SHALL be an input, CNT_WIDTH bits wide: the requested divisor.
REQ-011 Port tick SHALL be an output, 1 bit wide: a registered oversample strobe.
REQ-012 Port bit_tick SHALL be an output, 1 bit wide: a registered strobe that fires once per OVERSAMPLE ticks.
REQ-013 Port div_pending SHALL be an output, 1 bit wide: 1 while a loaded divisor has not yet been applied.
REQ-014 Port div_active SHALL be an output, CNT_WIDTH bits wide: the divisor currently in use.

Function
REQ-015 The tick period SHALL be div_active+1 enabled clocks; the counter runs 0..div_active, and on the edge where it equals div_active it goes to 0 with tick<=1, otherwise it increments with tick<=0.
REQ-016 When div_active=0, tick SHALL be 1 on every enabled cycle.
REQ-017 The oversample counter (width clog2(OVERSAMPLE), minimum 1 bit) SHALL advance only on the edge that asserts tick, wrapping from OVERSAMPLE-1 to 0; bit_tick SHALL assert on that same wrap edge, coincident with tick.
REQ-018 When OVERSAMPLE=1, bit_tick SHALL equal tick.
REQ-019 While enable=0, both counters SHALL hold their values and tick and bit_tick SHALL be 0; with no restart, counting SHALL resume from the held value.
REQ-020 On div_load=1, div_value SHALL be latched into a pending register and div_pending SHALL be set to 1.
REQ-021 A pending divisor SHALL become div_active on the counter wrap edge, and div_pending SHALL clear on that edge; the period that ends on that edge SHALL use the old divisor.
REQ-022 When div_load and a wrap occur on the same edge, div_value SHALL be applied directly at that wrap, and div_pending SHALL remain 0.
REQ-023 A second div_load while a divisor is pending SHALL overwrite the pending value (last write wins).
REQ-024 On restart=1, regardless of enable, both counters SHALL go to 0, tick and bit_tick SHALL go to 0, and any pending divisor SHALL be applied immediately with div_pending cleared.
REQ-025 When restart and div_load occur on the same edge, div_value SHALL become div_active immediately.
REQ-026 restart SHALL take priority over a wrap and over enable.
REQ-027 After a restart edge, the first tick SHALL assert on the (div_active+1)th subsequent enabled edge.
REQ-028 The divisor counter SHALL compare for equality only and SHALL never exceed div_active, because div_active changes only at a wrap or a restart.
REQ-029 Elaboration SHALL fail when DEFAULT_DIV >= 2^CNT_WIDTH or when OVERSAMPLE < 1.

Reset
REQ-030 When reset_n=0, asynchronously: both counters SHALL be 0, tick and bit_tick SHALL be 0, div_active SHALL be DEFAULT_DIV, the pending register SHALL be DEFAULT_DIV, and div_pending SHALL be 0.
REQ-031 Asserting reset_n mid-period or while a divisor is pending SHALL discard all state, including the pending divisor.
REQ-032 After reset_n deasserts with enable=1, the first tick SHALL assert on the (DEFAULT_DIV+1)th rising edge.

Verification
REQ-033 Defaults, with enable held at 1: tick pulses at edges 164, 328, 492, ...; bit_tick first pulses at edge 2624 (16 x 164); each pulse is exactly 1 cycle wide.
REQ-034 div_load with div_value=9 at mid-period edge 50: the period still ends at edge 164; div_pending is 1 during edges 51..163; div_active=9 from edge 164; the next ticks fall at edges 174 and 184.
REQ-035 div_load with div_value=3 on the exact wrap edge 164: div_pending stays 0; the next tick falls at edge 168.
REQ-036 enable deasserted for 20 cycles at counter value 100: no tick occurs; the next tick arrives 20 cycles later than the unpaused schedule.
REQ-037 restart at counter value 80, with div_load of 4 on the same edge: tick=0 on that edge; div_active=4; the next tick falls 5 enabled edges later; the oversample count is 0.
REQ-038 reset_n pulsed low for 3 ns between clock edges while a divisor is pending: outputs are immediately 0 and div_active=163; the pending value is lost; the first tick falls 164 edges after release.
